// File: rtl/fb_scanout_pkg.sv
// Shared framebuffer geometry, pixel record layout and scan-out FSM encoding.
package fb_scanout_pkg;

    localparam int unsigned FB_W    = 64;
    localparam int unsigned FB_H    = 64;
    localparam int unsigned FB_AW   = 12;
    localparam int unsigned COLOR_W = 12;

    localparam int unsigned X_W   = $clog2(FB_W);
    localparam int unsigned Y_W   = $clog2(FB_H);
    localparam int unsigned PIX_W = COLOR_W + Y_W + X_W;

    localparam logic [FB_AW-1:0] LAST_ADDR = FB_AW'(FB_W * FB_H - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // {y, x} concatenation is exactly the framebuffer address of the pixel
    typedef struct packed {
        logic [COLOR_W-1:0] color;
        logic [Y_W-1:0]     y;
        logic [X_W-1:0]     x;
    } pix_t;

    function automatic logic is_last_pixel(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        return (x == X_W'(FB_W - 1)) && (y == Y_W'(FB_H - 1));
    endfunction

endpackage

// File: rtl/fb_scanout_pix_fifo.sv
// Small output buffer for scanned pixels; head entry is shown combinationally and reads as zero when empty.
module pix_fifo
    import fb_scanout_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    parameter  int unsigned WIDTH = PIX_W,
    localparam int unsigned CW    = $clog2(DEPTH + 1),
    localparam int unsigned PW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             valid_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    // Depth need not be a power of two, so pointers wrap explicitly
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign pop_ok  = pop_i && (count_q != '0);
    assign push_ok = push_i && ((count_q != CW'(DEPTH)) || pop_ok);

    always_comb begin
        wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign valid_o = (count_q != '0);
    assign rdata_o = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer scan-out: raster-order reads of a 64x64 frame into a ready/valid pixel stream.
module fb_scanout
    import fb_scanout_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               FB_CEN,
    output logic               FB_WEN,
    output logic [FB_AW-1:0]   FB_A,
    input  logic [COLOR_W-1:0] FB_Q,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COLOR_W-1:0] pix_data,
    output logic [X_W-1:0]     pix_x,
    output logic [Y_W-1:0]     pix_y,
    output logic               sol,
    output logic               eof,
    output logic               busy,
    output logic               done
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    state_t           state_q, state_d;
    logic [FB_AW-1:0] addr_q, addr_d;
    logic [FB_AW-1:0] rd_addr_q, rd_addr_d;
    logic             inflight_q, inflight_d;
    logic             done_q, done_d;

    logic             issue;
    logic             credit;
    logic             xfer;
    logic             last_xfer;
    logic [CW-1:0]    fifo_count;
    logic [CW:0]      occ_after;
    logic             fifo_valid;
    pix_t             push_pix;
    pix_t             head_pix;

    // Occupancy counts the slot freed by this cycle's transfer so a full-rate stream fits in two entries
    assign occ_after = (CW+1)'(fifo_count) + (CW+1)'(inflight_q) - (CW+1)'(xfer);
    assign credit    = (occ_after < (CW+1)'(FIFO_DEPTH));

    assign xfer      = fifo_valid && pix_ready;
    assign last_xfer = xfer && eof;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start && !done_q)               state_d = SCAN;
            SCAN:    if (issue && (addr_q == LAST_ADDR)) state_d = DRAIN;
            DRAIN:   if (last_xfer)                      state_d = IDLE;
            default:                                     state_d = IDLE;
        endcase
    end

    always_comb begin
        issue  = (state_q == SCAN) && credit;
        FB_CEN = !issue;
        FB_WEN = 1'b1;
        busy   = (state_q != IDLE) || done_q;
    end

    always_comb begin
        addr_d = addr_q;
        if ((state_q == IDLE) && (state_d == SCAN)) begin
            addr_d = '0;
        end else if (issue && (addr_q != LAST_ADDR)) begin
            addr_d = addr_q + FB_AW'(1);
        end
        rd_addr_d  = issue ? addr_q : rd_addr_q;
        inflight_d = issue;
        done_d     = (state_q == DRAIN) && last_xfer;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q     <= '0;
            rd_addr_q  <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            rd_addr_q  <= rd_addr_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
        end
    end

    assign push_pix = '{color: FB_Q, y: rd_addr_q[FB_AW-1:X_W], x: rd_addr_q[X_W-1:0]};

    pix_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PIX_W)
    ) u_pix_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (inflight_q),
        .wdata_i (push_pix),
        .pop_i   (xfer),
        .rdata_o (head_pix),
        .valid_o (fifo_valid),
        .count_o (fifo_count)
    );

    assign FB_A      = addr_q;
    assign pix_valid = fifo_valid;
    assign pix_data  = head_pix.color;
    assign pix_x     = head_pix.x;
    assign pix_y     = head_pix.y;
    assign sol       = fifo_valid && (head_pix.x == '0);
    assign eof       = fifo_valid && is_last_pixel(head_pix.x, head_pix.y);
    assign done      = done_q;

endmodule
